// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute stage: lane geometry, opcodes and
// sequencer states.
package vec_pkg;

   localparam int LANES = 4;
   localparam int XLEN  = 32;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_XOR  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_SHL  = 4'd5,
      OP_SHR  = 4'd6,
      OP_ROTL = 4'd7,
      OP_MUL  = 4'd8,
      OP_PASS = 4'd9
   } alu_op_e;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_MUL_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU. MUL is sequenced by the parent through a shared
// multiplier, so it yields 0 here along with the reserved opcodes.
module vec_lane_alu
   import vec_pkg::*;
(
   input  logic [3:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_res
);

   logic [4:0] w_sh;
   logic [4:0] w_sh_inv;

   assign w_sh     = i_b[4:0];
   // Right-shift amount for the rotate; a zero rotate leaves both halves equal to i_a.
   assign w_sh_inv = 5'd0 - w_sh;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      o_res = '0;
      case (i_op)
         OP_ADD:  o_res = i_a + i_b;
         OP_SUB:  o_res = i_a - i_b;
         OP_XOR:  o_res = i_a ^ i_b;
         OP_AND:  o_res = i_a & i_b;
         OP_OR:   o_res = i_a | i_b;
         OP_SHL:  o_res = i_a << w_sh;
         OP_SHR:  o_res = i_a >> w_sh;
         OP_ROTL: o_res = (i_a << w_sh) | (i_a >> w_sh_inv);
         OP_PASS: o_res = i_a;
         default: o_res = '0;
      endcase
   end

endmodule

// File: rtl/vec_exe_stage.sv
// Four-lane vector execute stage: single-cycle lane ALUs plus a shared multiplier
// that walks the lanes over four cycles while holding the ID/EXE register with stop.
module vec_exe_stage
   import vec_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [3:0]       aluControl_in,
   input  logic [XLEN-1:0]  opA0_in,
   input  logic [XLEN-1:0]  opA1_in,
   input  logic [XLEN-1:0]  opA2_in,
   input  logic [XLEN-1:0]  opA3_in,
   input  logic [XLEN-1:0]  opB0_in,
   input  logic [XLEN-1:0]  opB1_in,
   input  logic [XLEN-1:0]  opB2_in,
   input  logic [XLEN-1:0]  opB3_in,
   input  logic [3:0]       rd_in,
   input  logic             regWrite_in,
   input  logic             memWrite_in,
   input  logic             resultSrc_in,
   input  logic [1:0]       column_in,
   output logic             stop,
   output logic [XLEN-1:0]  res0_out,
   output logic [XLEN-1:0]  res1_out,
   output logic [XLEN-1:0]  res2_out,
   output logic [XLEN-1:0]  res3_out,
   output logic             valid_out,
   output logic [3:0]       rd_out,
   output logic             regWrite_out,
   output logic             memWrite_out,
   output logic             resultSrc_out,
   output logic [1:0]       column_out
);

   logic [XLEN-1:0] w_op_a    [LANES];
   logic [XLEN-1:0] w_op_b    [LANES];
   logic [XLEN-1:0] w_alu_res [LANES];
   logic [XLEN-1:0] w_res_nxt [LANES];
   logic [XLEN-1:0] w_mul_prod;
   logic            w_is_mul;
   logic            w_stop;
   logic            w_hold_we;
   logic            w_load;
   state_e          w_state_nxt;
   logic [1:0]      w_cnt_nxt;

   state_e          r_state;
   logic [1:0]      r_cnt;
   logic [XLEN-1:0] r_mul_hold [LANES];
   logic [XLEN-1:0] r_res      [LANES];
   logic            r_valid;
   logic [3:0]      r_rd;
   logic            r_reg_write;
   logic            r_mem_write;
   logic            r_result_src;
   logic [1:0]      r_column;

   assign w_op_a[0] = opA0_in;
   assign w_op_a[1] = opA1_in;
   assign w_op_a[2] = opA2_in;
   assign w_op_a[3] = opA3_in;
   assign w_op_b[0] = opB0_in;
   assign w_op_b[1] = opB1_in;
   assign w_op_b[2] = opB2_in;
   assign w_op_b[3] = opB3_in;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      vec_lane_alu u_lane_alu (
         .i_op  (aluControl_in),
         .i_a   (w_op_a[g]),
         .i_b   (w_op_b[g]),
         .o_res (w_alu_res[g])
      );
   end

   // cnt is 0 in IDLE, so the same mux feeds lane 0 on the first MUL cycle.
   assign w_mul_prod = w_op_a[r_cnt] * w_op_b[r_cnt];
   assign w_is_mul   = (aluControl_in == OP_MUL);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stop      = 1'b0;
      w_hold_we   = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (valid_in && w_is_mul) begin
               w_hold_we   = 1'b1;
               w_cnt_nxt   = 2'd1;
               w_state_nxt = S_MUL_BUSY;
               w_stop      = 1'b1;
            end else if (valid_in) begin
               w_load = 1'b1;
            end
         end
         S_MUL_BUSY: begin
            if (!valid_in) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 2'd0;
            end else if (r_cnt == 2'd3) begin
               w_load      = 1'b1;
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 2'd0;
            end else begin
               w_hold_we = 1'b1;
               w_cnt_nxt = r_cnt + 2'd1;
               w_stop    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 2'd0;
         end
      endcase
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         w_res_nxt[i] = w_alu_res[i];
         if (r_state == S_MUL_BUSY)
            w_res_nxt[i] = (i == LANES - 1) ? w_mul_prod : r_mul_hold[i];
      end
   end

   // While reset is held the FSM already reads IDLE, so gate the hold request too.
   assign stop = w_stop & ~reset;

   // NOTE: the partial-product holding registers carry no reset; each entry is
   // written by its own MUL cycle before the completion cycle reads it.
   always_ff @(posedge clk) begin
      if (w_hold_we)
         r_mul_hold[r_cnt] <= w_mul_prod;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= 2'd0;
         r_valid      <= 1'b0;
         r_rd         <= '0;
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_result_src <= 1'b0;
         r_column     <= '0;
         for (int i = 0; i < LANES; i++)
            r_res[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_valid     <= w_load;
         r_reg_write <= w_load & regWrite_in;
         r_mem_write <= w_load & memWrite_in;
         if (w_load) begin
            r_rd         <= rd_in;
            r_result_src <= resultSrc_in;
            r_column     <= column_in;
            for (int i = 0; i < LANES; i++)
               r_res[i] <= w_res_nxt[i];
         end
      end
   end

   assign res0_out      = r_res[0];
   assign res1_out      = r_res[1];
   assign res2_out      = r_res[2];
   assign res3_out      = r_res[3];
   assign valid_out     = r_valid;
   assign rd_out        = r_rd;
   assign regWrite_out  = r_reg_write;
   assign memWrite_out  = r_mem_write;
   assign resultSrc_out = r_result_src;
   assign column_out    = r_column;

endmodule
